// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative shift-add multiplier / restoring divider holding the HI/LO registers
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   input  logic             we_hi,
   input  logic             we_lo,
   input  logic [WIDTH-1:0] wd,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;
   state_t             state_q, state_d;
   logic               is_div_q, negq_q, negr_q, accept, last;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   a_q, b_q, hi_q, lo_q, hi_d, lo_d, abs_a, abs_b, quot_s, rem_s;
   logic [2*WIDTH-1:0] acc_q, acc_d, prod_s;
   logic [WIDTH:0]     mul_sum, div_sh, div_tr;
   logic               sgn, sa, sb;
   assign accept = start && !busy;
   assign last   = cnt_q == CW'(WIDTH - 1);
   assign sgn    = ~op[0];
   assign sa     = sgn & srca[WIDTH-1];
   assign sb     = sgn & srcb[WIDTH-1];
   assign abs_a  = sa ? -srca : srca;
   assign abs_b  = sb ? -srcb : srcb;
   assign hi     = hi_q;
   assign lo     = lo_q;
   // state register
   always_ff @(posedge clk)
      state_q <= rst ? IDLE : state_d;
   // next-state: accepted start always enters CALC, even from DONE
   always_comb
      state_d = accept               ? CALC :
                state_q == CALC      ? (last ? SIGN : CALC) :
                state_q == SIGN      ? DONE :
                                       IDLE;
   // outputs decoded from the state
   always_comb begin
      busy = state_q == CALC || state_q == SIGN;
      done = state_q == DONE;
   end
   // one iteration step; the remainder never exceeds the divisor, so div_tr[WIDTH] is the trial sign,
   // and with a zero divisor the remainder only ever holds a WIDTH-bit dividend prefix
   always_comb begin
      mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
      div_sh  = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
      div_tr  = div_sh - {1'b0, b_q};
      acc_d   = is_div_q ? {div_tr[WIDTH] ? div_sh[WIDTH-1:0] : div_tr[WIDTH-1:0], acc_q[WIDTH-2:0], ~div_tr[WIDTH]}
                         : {mul_sum, acc_q[WIDTH-1:1]};
      prod_s  = negq_q ? -acc_q : acc_q;
      quot_s  = negq_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      rem_s   = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      hi_d    = state_q == SIGN ? (is_div_q ? rem_s : prod_s[2*WIDTH-1:WIDTH]) : (!busy && we_hi) ? wd : hi_q;
      lo_d    = state_q == SIGN ? (is_div_q ? quot_s : prod_s[WIDTH-1:0]) : (!busy && we_lo) ? wd : lo_q;
   end
   // datapath: latch magnitudes and sign flags on start, iterate in CALC, load HI/LO
   always_ff @(posedge clk) begin
      if (rst) begin
         is_div_q <= 1'b0;
         negq_q   <= 1'b0;
         negr_q   <= 1'b0;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
         if (accept) begin
            is_div_q <= op[1];
            negq_q   <= (sa ^ sb) & |srcb;
            negr_q   <= sa & op[1];
            cnt_q    <= '0;
            a_q      <= abs_a;
            b_q      <= abs_b;
            acc_q    <= '0;
         end else if (state_q == CALC) begin
            cnt_q <= cnt_q + 1'b1;
            acc_q <= acc_d;
            a_q   <= is_div_q ? {a_q[WIDTH-2:0], 1'b0} : a_q;
            b_q   <= is_div_q ? b_q : {1'b0, b_q[WIDTH-1:1]};
         end
      end
   end
endmodule
